ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port access controller for the 32x8 single-port synchronous RAM (ramlpm). It shares the RAM between two requesters, for example the switch-driven manual port and a display/scan engine. Each requester uses a req/gnt handshake. After reset the block optionally clears the RAM to a known value. It sits between the requesters and the ramlpm instance and owns the RAM's address, data and wren inputs.

Parameters:
ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32)
DATA_W, 8, RAM data width
INIT_VALUE, 8'h00, value written to every location during the post-reset clear
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go directly to RUN

Ports:
clock  in  1  system clock; same clock as the ramlpm instance
resetn  in  1  asynchronous, active-low reset
req0  in  1  port 0 request; held high until gnt0
we0  in  1  port 0: 1 = write, 0 = read; held with req0
addr0  in  ADDR_W  port 0 address; held with req0
wdata0  in  DATA_W  port 0 write data; held with req0
gnt0  out  1  port 0 command accepted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_W  port 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
ram_address  out  ADDR_W  to ramlpm address
ram_data  out  DATA_W  to ramlpm data
ram_wren  out  1  to ramlpm wren
ram_q  in  DATA_W  from ramlpm q
busy  out  1  high while the clear sequence runs

Behaviour:
- Reset is asynchronous and active-low. The clock port is named clock and the reset port is named resetn.
- Values while resetn is low:
  - gnt0/1 = 0, rvalid0/1 = 0, ram_wren = 0, ram_address = 0, ram_data = 0.
  - clear counter = 0, last_grant = 1 (so port 0 wins the first tie).
  - busy = CLEAR_ON_RESET.
- RAM model: the address, data and wren are sampled at a rising edge; q is valid for the whole following cycle (1-cycle read latency).
- States: CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise RUN.
- CLEAR state:
  - Each cycle drives ram_wren = 1, ram_address = counter, ram_data = INIT_VALUE, then increments the counter.
  - After the cycle with counter = 31, the next state is RUN. The clear takes exactly 32 cycles.
  - busy = 1 and gnt0/1 = 0 throughout; requests stay pending.
- RUN state arbitration (combinational within the cycle):
  - Only one requester active: that requester is granted.
  - Both requesting: the port that is not last_grant is granted (round-robin).
  - last_grant updates at the edge of every granted cycle.
  - Sustained dual requests alternate 0,1,0,1.
- Granted cycle:
  - gntN = 1, ram_address = addrN, ram_wren = weN, ram_data = wdataN.
  - The requester may drop or change its request on the next cycle.
  - A grant is possible every cycle (full throughput, no bubbles).
- No grant: ram_wren = 0; ram_address and ram_data hold their last values.
- Read completion: a granted read (we = 0) in cycle T sets rvalidN = 1 in cycle T+1 (registered), with rdataN = ram_q. A granted write never raises rvalid.
- rdata0/rdata1 are only defined while the matching rvalid is high; both may be driven from ram_q.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset asserted mid-clear or mid-read: all outputs go to their reset values immediately, any pending rvalid is dropped, and the clear restarts at address 0 after release.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum {CLEAR, RUN};
  - the ADDR_W/DATA_W defaults;
  - the PORT0/PORT1 index constants.
- One sub-module, rr_arbiter2: 2-input round-robin grant logic with a last_grant register. Inputs are req[1:0], advance and resetn; output is gnt[1:0].

Test Plan:
- Clear sequence: release resetn → busy = 1 for exactly 32 cycles, ram_wren = 1 with ram_address 0..31 and ram_data = 0x00. Then port 0 reads addr 17 → rdata0 = 0x00 with rvalid0 one cycle after gnt0.
- Write then read on different ports: port 0 writes 0xA5 to addr 5 (gnt0 same cycle). Port 1 then reads addr 5 → gnt1, and next cycle rvalid1 = 1 with rdata1 = 0xA5; rvalid0 stays 0.
- Contention: req0 and req1 held high for 6 cycles, all reads → gnt sequence 0,1,0,1,0,1 (port 0 first after reset); each rvalid follows its grant by 1 cycle.
- Back-to-back read-after-write: port 0 writes 0x3C to addr 7 in cycle T, port 1 reads addr 7 in cycle T+1 → rdata1 = 0x3C at T+2.
- Requests during clear: req1 raised on clear cycle 3 → gnt1 = 0 until the first RUN cycle, then granted in that cycle.
- Reset mid-operation: assert resetn low at clear address 12, and again the cycle after a granted read → outputs zero immediately, no rvalid afterward, and the clear restarts from address 0 (32 more busy cycles).

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM access controller.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic; the port not granted last wins a tie.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last_grant <= gnt[PORT1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters and
// optionally clears the RAM after reset.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int              ADDR_W         = ADDR_W_DEF,
  parameter int              DATA_W         = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output arb_state_e        state
);

  // Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
  // until gntN; a cycle with gntN high is the transfer, and the requester may
  // change or drop its request in the next cycle. Reads answer one cycle later
  // with rvalidN, and rdataN is meaningful only while rvalidN is high.

  localparam arb_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  arb_state_e        state_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_wren;
  logic [1:0]        arb_gnt;
  logic              rvalid0_q;
  logic              rvalid1_q;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .resetn  (resetn),
    .req     ({req1, req0}),
    .advance (state_q == RUN),
    .gnt     (arb_gnt)
  );

  always_comb begin
    nxt_addr = hold_addr;
    nxt_data = hold_data;
    nxt_wren = 1'b0;
    if (state_q == CLEAR) begin
      nxt_addr = clr_cnt;
      nxt_data = INIT_VALUE;
      nxt_wren = 1'b1;
    end else if (arb_gnt[PORT0]) begin
      nxt_addr = addr0;
      nxt_data = wdata0;
      nxt_wren = we0;
    end else if (arb_gnt[PORT1]) begin
      nxt_addr = addr1;
      nxt_data = wdata1;
      nxt_wren = we1;
    end
  end

  // The RAM-side outputs are combinational so a grant reaches the RAM in the
  // same cycle; gating with resetn forces them quiet while reset is held.
  always_comb begin
    gnt0        = resetn & arb_gnt[PORT0];
    gnt1        = resetn & arb_gnt[PORT1];
    ram_wren    = resetn & nxt_wren;
    ram_address = resetn ? nxt_addr : '0;
    ram_data    = resetn ? nxt_data : '0;
    busy        = (state_q == CLEAR);
    state       = state_q;
    rvalid0     = rvalid0_q;
    rvalid1     = rvalid1_q;
    rdata0      = ram_q;
    rdata1      = ram_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RESET_STATE;
      clr_cnt   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      hold_addr <= nxt_addr;
      hold_data <= nxt_data;
      rvalid0_q <= arb_gnt[PORT0] & ~we0;
      rvalid1_q <= arb_gnt[PORT1] & ~we1;
      if (state_q == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) begin
          state_q <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x8 synchronous RAM.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic       clock;
  logic       resetn;
  logic       req0, we0, gnt0, rvalid0;
  logic [4:0] addr0;
  logic [7:0] wdata0, rdata0;
  logic       req1, we1, gnt1, rvalid1;
  logic [4:0] addr1;
  logic [7:0] wdata1, rdata1;
  logic [4:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;
  logic       busy;
  arb_state_e dbg_state;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;

  ram_arbiter dut (
    .clock       (clock),
    .resetn      (resetn),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .gnt0        (gnt0),
    .rvalid0     (rvalid0),
    .rdata0      (rdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .gnt1        (gnt1),
    .rvalid1     (rvalid1),
    .rdata1      (rdata1),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .busy        (busy),
    .state       (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: one-cycle read latency, old data returned on a write cycle
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    ram_q = 8'h00;
  end
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drv0(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // Called one time unit after a rising edge, on the first clear cycle.
  task automatic run_clear(input int ncyc, input int req1_at);
    for (int k = 0; k < ncyc; k++) begin
      if (k == req1_at) drv1(1'b1, 1'b0, 5'd17, 8'h00);
      #1;
      chk("clr_busy", busy, 1);
      chk("clr_wren", ram_wren, 1);
      chk("clr_addr", ram_address, k);
      chk("clr_data", ram_data, 0);
      chk("clr_gnt", {gnt1, gnt0}, 0);
      tick;
    end
  endtask

  initial begin
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    drv0(1'b0, 1'b0, 5'd0, 8'h00);
    drv1(1'b0, 1'b0, 5'd0, 8'h00);
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_busy", busy, 1);
    tick;
    resetn = 1'b1;

    // clear, with port 1 requesting a read of 17 from clear cycle 3
    run_clear(32, 3);
    #1;
    chk("run_busy", busy, 0);
    chk("run_state", dbg_state, RUN);
    chk("c0_gnt", {gnt1, gnt0}, 2'b10);
    chk("c0_addr", ram_address, 17);
    chk("c0_wren", ram_wren, 0);

    tick; drv1(1'b0, 1'b0, 5'd0, 8'h00); drv0(1'b1, 1'b0, 5'd17, 8'h00); #1;
    chk("c1_gnt", {gnt1, gnt0}, 2'b01);
    chk("c1_rvalid", {rvalid1, rvalid0}, 2'b10);
    chk("c1_rdata1", rdata1, 8'h00);
    chk("c1_addr", ram_address, 17);

    tick; drv0(1'b1, 1'b1, 5'd5, 8'hA5); #1;
    chk("c2_gnt", {gnt1, gnt0}, 2'b01);
    chk("c2_rvalid", {rvalid1, rvalid0}, 2'b01);
    chk("c2_rdata0", rdata0, 8'h00);
    chk("c2_wren", ram_wren, 1);
    chk("c2_addr", ram_address, 5);
    chk("c2_data", ram_data, 8'hA5);

    tick; drv0(1'b0, 1'b0, 5'd0, 8'h00); drv1(1'b1, 1'b0, 5'd5, 8'h00); #1;
    chk("c3_gnt", {gnt1, gnt0}, 2'b10);
    chk("c3_rvalid", {rvalid1, rvalid0}, 2'b00);
    chk("c3_wren", ram_wren, 0);

    tick; drv1(1'b0, 1'b0, 5'd0, 8'h00); #1;
    chk("c4_gnt", {gnt1, gnt0}, 2'b00);
    chk("c4_rvalid", {rvalid1, rvalid0}, 2'b10);
    chk("c4_rdata1", rdata1, 8'hA5);
    chk("c4_wren", ram_wren, 0);
    chk("c4_addr_hold", ram_address, 5);

    // contention: six cycles of dual reads, then release
    for (int i = 0; i < 7; i++) begin
      tick;
      if (i < 6) begin
        drv0(1'b1, 1'b0, 5'd17, 8'h00);
        drv1(1'b1, 1'b0, 5'd5, 8'h00);
      end else begin
        drv0(1'b0, 1'b0, 5'd0, 8'h00);
        drv1(1'b0, 1'b0, 5'd0, 8'h00);
      end
      #1;
      exp_gnt = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      exp_rv  = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_gnt", {gnt1, gnt0}, exp_gnt);
      chk("cont_rvalid", {rvalid1, rvalid0}, exp_rv);
      if (exp_gnt == 2'b01) chk("cont_addr0", ram_address, 17);
      if (exp_gnt == 2'b10) chk("cont_addr1", ram_address, 5);
      if (exp_rv == 2'b01) chk("cont_rdata0", rdata0, 8'h00);
      if (exp_rv == 2'b10) chk("cont_rdata1", rdata1, 8'hA5);
    end

    // back-to-back read-after-write across ports
    tick; drv0(1'b1, 1'b1, 5'd7, 8'h3C); #1;
    chk("raw_gnt0", {gnt1, gnt0}, 2'b01);
    chk("raw_wren", ram_wren, 1);
    tick; drv0(1'b0, 1'b0, 5'd0, 8'h00); drv1(1'b1, 1'b0, 5'd7, 8'h00); #1;
    chk("raw_gnt1", {gnt1, gnt0}, 2'b10);
    chk("raw_addr", ram_address, 7);
    chk("raw_rd_wren", ram_wren, 0);
    tick; drv1(1'b0, 1'b0, 5'd0, 8'h00); #1;
    chk("raw_rvalid", {rvalid1, rvalid0}, 2'b10);
    chk("raw_rdata1", rdata1, 8'h3C);

    // reset in the cycle after a granted read
    tick; drv0(1'b1, 1'b0, 5'd7, 8'h00); #1;
    chk("rr_gnt", {gnt1, gnt0}, 2'b01);
    tick; drv0(1'b0, 1'b0, 5'd0, 8'h00); #1;
    chk("rr_pre_rvalid", rvalid0, 1);
    chk("rr_pre_rdata0", rdata0, 8'h3C);
    resetn = 1'b0; #1;
    chk("rr_rvalid", {rvalid1, rvalid0}, 2'b00);
    chk("rr_gnt_rst", {gnt1, gnt0}, 2'b00);
    chk("rr_wren", ram_wren, 0);
    chk("rr_addr", ram_address, 0);
    chk("rr_data", ram_data, 0);
    chk("rr_busy", busy, 1);
    tick;
    chk("rr_hold_rvalid", {rvalid1, rvalid0}, 2'b00);
    resetn = 1'b1;

    // reset again at clear address 12, then a full clear
    run_clear(12, -1);
    #1;
    chk("mc_addr12", ram_address, 12);
    resetn = 1'b0; #1;
    chk("mc_wren", ram_wren, 0);
    chk("mc_addr", ram_address, 0);
    chk("mc_busy", busy, 1);
    tick;
    resetn = 1'b1;
    run_clear(32, -1);
    #1;
    chk("end_busy", busy, 0);
    drv0(1'b1, 1'b0, 5'd7, 8'h00); #1;
    chk("end_gnt", {gnt1, gnt0}, 2'b01);
    tick; drv0(1'b0, 1'b0, 5'd0, 8'h00); #1;
    chk("end_rvalid", {rvalid1, rvalid0}, 2'b01);
    chk("end_rdata0", rdata0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
